wb_stage_pipe: RTL
==================

// Module: wb_stage_pipe
// PURPOSE
//  Registered, parametrised write-back stage: the MEM/WB pipeline register plus the write-back result path.
//  Selects the write-back result from one of three sources: ALU result, aligned load data, or link address.
//  For loads, extracts byte/half/word/dword lanes and sign- or zero-extends them.
//  Supports stall, flush, misalignment detection, r0 write suppression and a retired-write counter.
//  Sits between the memory stage and the register file; its outputs drive the RF write port and forwarding.
// PARAMETERS
//  DATA_W     32  datapath width; legal values 32 or 64
//  REG_AW     5   register-index width
//  ZERO_SUPP  1   1 = writes to register 0 are dropped (regwrite_out forced 0)
//  CNT_W      32  width of retire_cnt
//  LANE_AW    derived localparam = $clog2(DATA_W/8); not overridable
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high reset
//  stall          in   1        hold the pipeline register contents
//  flush          in   1        squash the instruction being captured
//  in_valid       in   1        the instruction at the inputs is real
//  regwrite       in   1        instruction writes the RF
//  wbsel          in   2        0 = ALU, 1 = MEM, 2 = LINK, 3 = reserved (acts as ALU)
//  memsize        in   2        0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W=64 only)
//  memsigned      in   1        1 = sign-extend the load result
//  addr_lo        in   LANE_AW  low byte-address bits of the load
//  rdata          in   DATA_W   raw memory read word
//  alurslt        in   DATA_W   ALU result
//  linkaddr       in   DATA_W   PC+8 / link value
//  wrreg          in   REG_AW   destination register
//  regwrite_out   out  1        RF write enable
//  wrreg_out      out  REG_AW   RF write index
//  wrdata         out  DATA_W   RF write data
//  wb_valid       out  1        registered valid
//  wb_regdata     out  DATA_W   diagnostic copy of wrdata
//  wb_regwrite    out  1        diagnostic copy of regwrite_out
//  misalign_err   out  1        one-cycle pulse: a misaligned load was retired
//  retire_cnt     out  CNT_W    count of committed RF writes
// BEHAVIOUR
//  - Single clock domain, clk.
//  - reset=1 asynchronously clears every register: wb_valid, regwrite_out, wrreg_out, wrdata, misalign_err,
//    retire_cnt all 0; the diagnostic outputs follow to 0.
//  - Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
//  - Capture priority per edge: flush > stall > load.
//    - flush: wb_valid<=0, regwrite_out<=0, misalign_err<=0; data/index registers don't-care (hold).
//    - stall (no flush): all registers hold; misalign_err<=0; retire_cnt holds.
//    - otherwise: capture computed values.
//  - Result mux (combinational, before the register): wbsel selects alurslt, load-aligned rdata or linkaddr.
//  - Load align, little-endian lane order:
//    - lane = addr_lo; byte = rdata[8*lane +: 8]; half = rdata[16*addr_lo[LANE_AW-1:1] +: 16].
//    - word = rdata[32*addr_lo[LANE_AW-1] +: 32] when DATA_W=64, else the whole rdata.
//    - extend to DATA_W by sign bit when memsigned, else by zeros; dword passes rdata through.
//  - Misaligned (wbsel=MEM only):
//    - conditions: half with addr_lo[0]=1; word with addr_lo[1:0]!=0; dword with addr_lo!=0;
//      memsize=3 when DATA_W=32.
//    - effect: the write is suppressed (regwrite_out<=0), misalign_err<=1 for exactly one cycle,
//      wrdata still captured.
//  - Commit: regwrite_out <= in_valid & regwrite & ~misalign & ~(ZERO_SUPP & wrreg==0).
//  - retire_cnt increments on an edge iff the registered commit being captured is 1;
//    wraps modulo 2^CNT_W with no saturation.
//  - wb_regdata = wrdata and wb_regwrite = regwrite_out; both are purely combinational copies.
//  - Reset asserted mid-stall or mid-flush: reset wins immediately, and the first capture follows its release.
// STRUCTURE
//  - wb_pkg: WBSEL_ALU/MEM/LINK and MEMSZ_B/H/W/D localparams, plus a lane_aw() function.
//  - Sub-module wb_load_align: combinational (rdata, memsize, memsigned, addr_lo) -> (data, misalign),
//    parametrised by DATA_W.
//  - Top module: result mux, pipeline registers, commit logic, counter.
// TESTING
//  - Reset: assert reset mid-cycle -> every output is 0 asynchronously, before the next clk edge.
//  - ALU path: wbsel=0, alurslt=32'h1234_5678, wrreg=5, regwrite=1 ->
//    next cycle wrdata=32'h1234_5678, wrreg_out=5, regwrite_out=1, retire_cnt=1.
//  - Signed byte load: rdata=32'h80FF_7F01, memsize=0, addr_lo=3, memsigned=1 -> wrdata=32'hFFFF_FF80;
//    with memsigned=0 -> 32'h0000_0080.
//  - Misaligned half: memsize=1, addr_lo=1 -> regwrite_out=0, misalign_err=1 for exactly one cycle,
//    retire_cnt unchanged.
//  - r0 suppression: wrreg=0, regwrite=1 -> regwrite_out=0.
//  - Stall and flush:
//    - stall=1 for 3 cycles -> outputs frozen, counter unchanged.
//    - stall=1 with flush=1 -> wb_valid=0, regwrite_out=0.
//    - DATA_W=64 build: memsize=3, addr_lo=0 -> rdata passes through.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back stage constants and the lane-address width helper.
package wb_pkg;
   localparam logic [1:0] WBSEL_ALU  = 2'd0;
   localparam logic [1:0] WBSEL_MEM  = 2'd1;
   localparam logic [1:0] WBSEL_LINK = 2'd2;
   localparam logic [1:0] MEMSZ_B    = 2'd0;
   localparam logic [1:0] MEMSZ_H    = 2'd1;
   localparam logic [1:0] MEMSZ_W    = 2'd2;
   localparam logic [1:0] MEMSZ_D    = 2'd3;
   function automatic int lane_aw(input int data_w);
      return $clog2(data_w / 8);
   endfunction
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: extracts the addressed little-endian lane of a load and sign/zero-extends it.
//   rdata/memsize/memsigned/addr_lo in -> data (DATA_W, extended lane) and misalign out.
module wb_load_align import wb_pkg::*; #(
   parameter  int DATA_W  = 32,
   localparam int LANE_AW = lane_aw(DATA_W)
) (
   input  logic [DATA_W-1:0]  rdata,
   input  logic [1:0]         memsize,
   input  logic               memsigned,
   input  logic [LANE_AW-1:0] addr_lo,
   output logic [DATA_W-1:0]  data,
   output logic               misalign
);
   logic [DATA_W-1:0] sh_b, sh_h, sh_w, ext_b, ext_h, ext_w;
   always_comb begin
      sh_b  = rdata >> {addr_lo, 3'b000};
      sh_h  = rdata >> {addr_lo[LANE_AW-1:1], 4'b0000};
      // a 32-bit datapath has only one word lane, so the top address bit is ignored there
      sh_w  = (DATA_W == 64) ? rdata >> {addr_lo[LANE_AW-1], 5'b00000} : rdata;
      ext_b = memsigned ? DATA_W'($signed(sh_b[7:0]))  : DATA_W'(sh_b[7:0]);
      ext_h = memsigned ? DATA_W'($signed(sh_h[15:0])) : DATA_W'(sh_h[15:0]);
      ext_w = memsigned ? DATA_W'($signed(sh_w[31:0])) : DATA_W'(sh_w[31:0]);
      data  = (memsize == MEMSZ_B) ? ext_b :
              (memsize == MEMSZ_H) ? ext_h :
              (memsize == MEMSZ_W) ? ext_w : rdata;
      misalign = (memsize == MEMSZ_H) ? addr_lo[0] :
                 (memsize == MEMSZ_W) ? |addr_lo[1:0] :
                 (memsize == MEMSZ_D) ? ((DATA_W == 32) || (|addr_lo)) : 1'b0;
   end
endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MEM/WB pipeline register with result select, load align, commit and retire counter.
//   in : clk, reset (async, active-high), stall, flush, in_valid, regwrite, wbsel, memsize,
//        memsigned, addr_lo, rdata, alurslt, linkaddr, wrreg
//   out: regwrite_out, wrreg_out, wrdata, wb_valid, wb_regdata, wb_regwrite, misalign_err, retire_cnt
module wb_stage_pipe import wb_pkg::*; #(
   parameter  int DATA_W    = 32,
   parameter  int REG_AW    = 5,
   parameter  int ZERO_SUPP = 1,
   parameter  int CNT_W     = 32,
   localparam int LANE_AW   = lane_aw(DATA_W)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic               regwrite,
   input  logic [1:0]         wbsel,
   input  logic [1:0]         memsize,
   input  logic               memsigned,
   input  logic [LANE_AW-1:0] addr_lo,
   input  logic [DATA_W-1:0]  rdata,
   input  logic [DATA_W-1:0]  alurslt,
   input  logic [DATA_W-1:0]  linkaddr,
   input  logic [REG_AW-1:0]  wrreg,
   output logic               regwrite_out,
   output logic [REG_AW-1:0]  wrreg_out,
   output logic [DATA_W-1:0]  wrdata,
   output logic               wb_valid,
   output logic [DATA_W-1:0]  wb_regdata,
   output logic               wb_regwrite,
   output logic               misalign_err,
   output logic [CNT_W-1:0]   retire_cnt
);
   logic [DATA_W-1:0] ld_data, wrdata_d, wrdata_q;
   logic [REG_AW-1:0] wrreg_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ld_mis, mis_d, commit_d, valid_q, regwrite_q, mis_q;

   wb_load_align #(.DATA_W(DATA_W)) u_align (
      .rdata    (rdata),
      .memsize  (memsize),
      .memsigned(memsigned),
      .addr_lo  (addr_lo),
      .data     (ld_data),
      .misalign (ld_mis)
   );

   always_comb begin
      wrdata_d = (wbsel == WBSEL_MEM)  ? ld_data  :
                 (wbsel == WBSEL_LINK) ? linkaddr : alurslt;
      // misalignment only matters for a real load; other sources ignore memsize/addr_lo
      mis_d    = in_valid & (wbsel == WBSEL_MEM) & ld_mis;
      commit_d = in_valid & regwrite & ~mis_d & ~((ZERO_SUPP != 0) && (wrreg == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         wrreg_q    <= '0;
         wrdata_q   <= '0;
         mis_q      <= 1'b0;
         cnt_q      <= '0;
      end else if (flush) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         mis_q      <= 1'b0;
      end else if (stall) begin
         mis_q      <= 1'b0;
      end else begin
         valid_q    <= in_valid;
         regwrite_q <= commit_d;
         wrreg_q    <= wrreg;
         wrdata_q   <= wrdata_d;
         mis_q      <= mis_d;
         cnt_q      <= cnt_q + CNT_W'(commit_d);
      end
   end

   assign wb_valid     = valid_q;
   assign regwrite_out = regwrite_q;
   assign wrreg_out    = wrreg_q;
   assign wrdata       = wrdata_q;
   assign misalign_err = mis_q;
   assign retire_cnt   = cnt_q;
   assign wb_regdata   = wrdata_q;
   assign wb_regwrite  = regwrite_q;
endmodule
